key_expansion_seq: RTL and testbench
====================================

// Module: key_expansion_seq
// PURPOSE
//  Iterative AES key schedule (FIPS-197 sec 5.2), directly upstream of the cipher core.
//  Expands a Nk-word cipher key into the flat round-key bus consumed by the cipher (round r at bits 128*r +: 128).
//  Produces one 32-bit schedule word per clock and signals completion with keys_valid/done.
// PARAMETERS
//  Nk  4       key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256)
//  Nr  Nk+6    number of rounds
//  NW  4*(Nr+1) total schedule words (localparam; not overridable)
// PORTS
//  clks        in   1              clock, all logic on rising edge
//  reset       in   1              synchronous, active-high
//  start       in   1              request expansion of key_in; sampled only in IDLE
//  key_in      in   32*Nk          cipher key, word 0 at MSB end ([0:31]); captured on accepted start
//  busy        out  1              high in EXPAND
//  done        out  1              one-cycle pulse when schedule complete
//  keys_valid  out  1              keys bus complete and stable
//  keys        out  128*(Nr+1)     round keys, w[0] at bits [0:31], big-endian bit order [0:N-1]
// BEHAVIOUR
//  - Reset (any state, including mid-expansion): state=IDLE, busy=0, done=0, keys_valid=0, keys=0, i=0, rcon=8'h01.
//  - FSM IDLE -> EXPAND -> FINISH -> IDLE.
//  - IDLE: on start=1, w[0..Nk-1] <= key_in in one cycle, i <= Nk, rcon <= 8'h01, keys_valid <= 0, -> EXPAND.
//  - EXPAND: each cycle writes w[i] = w[i-Nk] ^ temp, where temp = w[i-1] and:
//      i mod Nk == 0      : temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon <= xtime(rcon)
//      Nk==8, i mod 8 == 4: temp = SubWord(w[i-1])
//    i <= i+1; when i == NW-1 is written -> FINISH.
//  - xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00); rcon never exceeds 8'h36 for legal Nk.
//  - i is a 6-bit counter (max 59); mod-Nk tracked by a separate wrapping counter (no divider).
//  - FINISH: done=1 and keys_valid=1 for that cycle -> IDLE; keys_valid stays 1 until next accepted start or reset.
//  - Latency: start sampled at edge E; done high in the cycle after edge E+(NW-Nk), i.e. NW-Nk+1 cycles (Nk=4: 41, Nk=6: 47, Nk=8: 53).
//  - start while busy/FINISH is ignored (no queuing); key_in is don't-care outside an accepted start.
//  - keys bits not yet written during EXPAND hold previous contents; consumer must gate on keys_valid.
//  - start and reset same cycle: reset wins.
// CONFIGURATION
//  - Macro KEXP_ROUND_VALID_EN:
//    defined     : adds output round_valid [0:Nr] ; bit r set once words 4r..4r+3 written (cleared by reset/accepted start),
//                  letting the cipher begin round r before the full schedule completes.
//    not defined : port absent; only keys_valid/done indicate availability.
// STRUCTURE
//  - Shared package aes_pkg: SBOX constant table (256x8), RCON start value 8'h01, xtime function,
//    word_t (32-bit) typedef, NW/Nr helper constants.
//  - One sub-module aes_sbox_word: combinational 4-byte SubWord (four SBOX lookups), instantiated once;
//    all other logic (FSM, counters, rcon, word write mux) lives in this module.
// TESTING
//  1 Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c -> w[4]=a0fafe17, w[43]=b6630ca6, done 41 cycles after start.
//  2 Nk=4, key 000102030405060708090a0b0c0d0e0f -> keys[128*10+:128]=13111d7fe3944a17f307a78b4d2b30c5.
//  3 Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[51]=01002202, done after 47 cycles.
//  4 Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[59]=706c631e, done after 53.
//  5 Reset asserted at EXPAND i=20, then start with new key -> busy/keys_valid drop to 0, keys=0, fresh correct schedule.
//  6 start pulsed repeatedly while busy -> ignored; exactly one done pulse; keys_valid held until next accepted start.
//  (macro on) case 1: round_valid[0] set cycle after start, round_valid[r] after word 4r+3, all ones at done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, Rcon seed, xtime and schedule-size helpers.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RconInit = 8'h01;

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic int unsigned nr_of(int unsigned nk);
    return nk + 6;
  endfunction

  function automatic int unsigned nw_of(int unsigned nk);
    return 4 * (nk + 7);
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int b = 0; b < 4; b++) begin
      data_out[8*b +: 8] = Sbox[data_in[8*b +: 8]];
    end
  end

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule, one 32-bit word per clock into a flat round-key bus.
// Optional macro KEXP_ROUND_VALID_EN adds a per-round availability vector round_valid.
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = Nk + 6
) (
  input  logic                   clks,
  input  logic                   reset,
  input  logic                   start,
  input  logic [0:32*Nk-1]       key_in,
  output logic                   busy,
  output logic                   done,
  output logic                   keys_valid,
  output logic [0:128*(Nr+1)-1]  keys
`ifdef KEXP_ROUND_VALID_EN
  ,
  output logic [0:Nr]            round_valid
`endif
);

  localparam int unsigned NW = 4 * (Nr + 1);

  typedef enum logic [1:0] {StIdle, StExpand, StFinish} state_e;

  state_e      state_q;
  word_t       w_q [NW];
  logic [5:0]  i_q;
  logic [2:0]  kmod_q;   // i mod Nk, kept as a wrapping counter
  logic [7:0]  rcon_q;

  word_t prev_word, back_word, sub_in, sub_out, temp, new_word;
  logic  last_word;

  aes_sbox_word u_sbox (
    .data_in  (sub_in),
    .data_out (sub_out)
  );

  always_comb begin
    prev_word = w_q[i_q - 6'd1];
    back_word = w_q[i_q - 6'(Nk)];
    sub_in    = (kmod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (kmod_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (Nk == 8 && kmod_q == 3'd4) begin
      temp = sub_out;
    end else begin
      temp = prev_word;
    end
    new_word  = back_word ^ temp;
    last_word = (i_q == 6'(NW - 1));
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      i_q        <= '0;
      kmod_q     <= '0;
      rcon_q     <= RconInit;
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
`ifdef KEXP_ROUND_VALID_EN
      round_valid <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int j = 0; j < Nk; j++) w_q[j] <= key_in[32*j +: 32];
            i_q        <= 6'(Nk);
            kmod_q     <= '0;
            rcon_q     <= RconInit;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state_q    <= StExpand;
`ifdef KEXP_ROUND_VALID_EN
            // Rounds fully covered by the raw key are available immediately.
            for (int r = 0; r <= Nr; r++) round_valid[r] <= (4 * r + 3 < Nk);
`endif
          end
        end
        StExpand: begin
          w_q[i_q] <= new_word;
          i_q      <= i_q + 6'd1;
          kmod_q   <= (kmod_q == 3'(Nk - 1)) ? 3'd0 : kmod_q + 3'd1;
          if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
`ifdef KEXP_ROUND_VALID_EN
          if (i_q[1:0] == 2'b11) round_valid[i_q[5:2]] <= 1'b1;
`endif
          if (last_word) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            state_q    <= StFinish;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  for (genvar j = 0; j < NW; j++) begin : g_pack
    assign keys[32*j +: 32] = w_q[j];
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq with AES-128/192/256 instances.
module tb_key_expansion_seq;

  logic clks = 1'b0;
  always #5 clks = ~clks;

  logic reset;
  logic start4, start6, start8;
  logic [0:127] key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic busy4, done4, kv4, busy6, done6, kv6, busy8, done8, kv8;
  logic [0:128*11-1] keys4;
  logic [0:128*13-1] keys6;
  logic [0:128*15-1] keys8;
`ifdef KEXP_ROUND_VALID_EN
  logic [0:10] rv4;
  logic [0:12] rv6;
  logic [0:14] rv8;
`endif

  int checks = 0;
  int failures = 0;

  key_expansion_seq #(.Nk(4)) u4 (
    .clks(clks), .reset(reset), .start(start4), .key_in(key4),
    .busy(busy4), .done(done4), .keys_valid(kv4), .keys(keys4)
`ifdef KEXP_ROUND_VALID_EN
    , .round_valid(rv4)
`endif
  );
  key_expansion_seq #(.Nk(6)) u6 (
    .clks(clks), .reset(reset), .start(start6), .key_in(key6),
    .busy(busy6), .done(done6), .keys_valid(kv6), .keys(keys6)
`ifdef KEXP_ROUND_VALID_EN
    , .round_valid(rv6)
`endif
  );
  key_expansion_seq #(.Nk(8)) u8 (
    .clks(clks), .reset(reset), .start(start8), .key_in(key8),
    .busy(busy8), .done(done8), .keys_valid(kv8), .keys(keys8)
`ifdef KEXP_ROUND_VALID_EN
    , .round_valid(rv8)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int sel);
    case (sel)
      4:       return done4;
      6:       return done6;
      default: return done8;
    endcase
  endfunction

  // One-cycle start pulse; lat counts cycles from the start cycle to the done cycle.
  task automatic run(input int sel, output int lat);
    @(negedge clks);
    start4 = (sel == 4);
    start6 = (sel == 6);
    start8 = (sel == 8);
    @(negedge clks);
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    lat = 1;
    while (!sel_done(sel) && lat < 200) begin
      @(negedge clks);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    reset  = 1'b1;
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    key4   = '0;
    key6   = '0;
    key8   = '0;
    repeat (3) @(negedge clks);
    reset = 1'b0;
    @(negedge clks);
    check("rst_busy", 128'(busy4), 128'(0));
    check("rst_done", 128'(done4), 128'(0));
    check("rst_kv", 128'(kv4), 128'(0));
    check("rst_keys_zero", 128'(|keys4), 128'(0));

    // AES-128 reference key
    key4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run(4, lat);
    check("lat128", 128'(lat), 128'(41));
    check("kv128_at_done", 128'(kv4), 128'(1));
    check("w4_128", 128'(keys4[32*4 +: 32]), 128'(32'ha0fafe17));
    check("w43_128", 128'(keys4[32*43 +: 32]), 128'(32'hb6630ca6));
    check("rk10_128", keys4[128*10 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEXP_ROUND_VALID_EN
    check("rv_all_at_done", 128'(rv4), 128'(11'h7ff));
`endif
    @(negedge clks);
    check("done_one_pulse", 128'(done4), 128'(0));
    check("busy_after_done", 128'(busy4), 128'(0));
    check("kv_held", 128'(kv4), 128'(1));

    // Repeated start while busy must be ignored
    @(negedge clks);
    key4   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start4 = 1'b1;
    @(negedge clks);
    start4 = 1'b0;
    key4   = 128'hdeadbeef_00000000_ffffffff_12345678;
    check("busy_after_start", 128'(busy4), 128'(1));
    check("kv_drop_on_start", 128'(kv4), 128'(0));
`ifdef KEXP_ROUND_VALID_EN
    check("rv_after_start", 128'(rv4), 128'({1'b1, 10'b0}));
`endif
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      start4 = (c < 20) && (c % 2 == 0);
      key4   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clks);
      if (done4) pulses++;
    end
    start4 = 1'b0;
    check("one_done_pulse", 128'(pulses), 128'(1));
    check("kv_held_idle", 128'(kv4), 128'(1));
    check("rk10_after_ignored", keys4[128*10 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192
    key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    run(6, lat);
    check("lat192", 128'(lat), 128'(47));
    check("w6_192", 128'(keys6[32*6 +: 32]), 128'(32'hfe0c91f7));
    check("w7_192", 128'(keys6[32*7 +: 32]), 128'(32'h2402f5a5));
    check("w51_192", 128'(keys6[32*51 +: 32]), 128'(32'h01002202));

    // AES-256
    key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run(8, lat);
    check("lat256", 128'(lat), 128'(53));
    check("w8_256", 128'(keys8[32*8 +: 32]), 128'(32'h9ba35411));
    check("w12_256", 128'(keys8[32*12 +: 32]), 128'(32'ha8b09c1a));
    check("w59_256", 128'(keys8[32*59 +: 32]), 128'(32'h706c631e));

    // Reset mid-expansion at i=20, with start asserted in the same cycle
    @(negedge clks);
    key4   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start4 = 1'b1;
    @(negedge clks);
    start4 = 1'b0;
    repeat (16) @(negedge clks);
    check("busy_mid_expand", 128'(busy4), 128'(1));
    reset  = 1'b1;
    start4 = 1'b1;
    @(negedge clks);
    reset  = 1'b0;
    start4 = 1'b0;
    check("midrst_busy", 128'(busy4), 128'(0));
    check("midrst_kv", 128'(kv4), 128'(0));
    check("midrst_keys_zero", 128'(|keys4), 128'(0));
    check("midrst_kv256", 128'(kv8), 128'(0));
    @(negedge clks);
    check("reset_beats_start", 128'(busy4), 128'(0));

    key4 = 128'h000102030405060708090a0b0c0d0e0f;
    run(4, lat);
    check("lat_after_rst", 128'(lat), 128'(41));
    check("rk1_k2", keys4[128*1 +: 128], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("rk10_k2", keys4[128*10 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
